// File: rtl/spas_skid_2_h.sv
// Two-entry registered skid buffer: out_data, out_valid, in_ready and count
// all come straight from flops, so out_ready never reaches in_ready combinationally.
module spas_skid_2_h #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             occ, occ_n;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             push, pop;
  logic             main_ld, main_from_skid, skid_ld;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = main_q;
  assign count     = occ;

  always_comb begin
    occ_n          = occ;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (occ)
      EMPTY: begin
        if (push) begin
          main_ld = 1'b1;
          occ_n   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_ld = 1'b1;
        end else if (push) begin
          skid_ld = 1'b1;
          occ_n   = FULL;
        end else if (pop) begin
          occ_n   = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          occ_n          = ONE;
        end
      end
      default: occ_n = EMPTY;
    endcase
    // Flush kills occupancy only; data flops keep their contents.
    if (flush) begin
      occ_n   = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  // in_ready doubles as the rdy_en flop: cleared by reset, first set on the
  // edge after release, so nothing is accepted in the first post-reset cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      main_q    <= RST_DATA;
      skid_q    <= RST_DATA;
    end else begin
      occ       <= occ_n;
      out_valid <= (occ_n != EMPTY);
      in_ready  <= (occ_n != FULL);
      if (main_ld) main_q <= main_from_skid ? skid_q : in_data;
      if (skid_ld) skid_q <= in_data;
    end
  end

  count_legal: assert property (@(posedge clk) disable iff (reset) count != 2'd3);

endmodule

// File: tb/tb_spas_skid_2_h.sv
// Directed and random bench for spas_skid_2_h with a queue-based reference model.
module tb_spas_skid_2_h;

  localparam int unsigned      W    = 32;
  localparam logic [W-1:0]     RSTV = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   count;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];
  logic         m_ready = 1'b0;

  spas_skid_2_h #(.WIDTH(W), .RST_DATA(RSTV)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".in_ready"}, W'(in_ready), W'(m_ready));
    chk({tag, ".out_valid"}, W'(out_valid), W'(sb.size() != 0));
    chk({tag, ".count"}, W'(count), W'(sb.size()));
    if (sb.size() != 0) chk({tag, ".out_data"}, out_data, sb[0]);
  endtask

  // Entered 1 time unit after a rising edge; returns likewise.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic r, input logic f);
    logic push, pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    chk_state(tag);
    push = v & m_ready;
    pop  = (sb.size() != 0) & r;
    if (f) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(d);
    end
    m_ready = (sb.size() != 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_release();
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    sb.delete();
    m_ready = 1'b0;
    chk("rst.out_data", out_data, RSTV);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         v, r, f;

    // 1: reset, first post-reset cycle refuses the offered word
    do_reset_release();
    cycle("rst0", 1'b1, 32'h99, 1'b1, 1'b0);
    cycle("rst1", 1'b0, 32'h0, 1'b1, 1'b0);

    // 2: streaming at full rate
    cycle("strm", 1'b1, 32'h11, 1'b1, 1'b0);
    cycle("strm", 1'b1, 32'h22, 1'b1, 1'b0);
    cycle("strm", 1'b1, 32'h33, 1'b1, 1'b0);
    cycle("strm", 1'b1, 32'h44, 1'b1, 1'b0);
    cycle("strm", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("strm", 1'b0, 32'h0, 1'b1, 1'b0);

    // 3: backpressure fills both entries, C3 is held until there is room
    cycle("bp", 1'b1, 32'hA1, 1'b0, 1'b0);
    cycle("bp", 1'b1, 32'hB2, 1'b0, 1'b0);
    cycle("bp", 1'b1, 32'hC3, 1'b0, 1'b0);
    cycle("bp", 1'b1, 32'hC3, 1'b0, 1'b0);
    cycle("bp", 1'b1, 32'hC3, 1'b1, 1'b0);
    cycle("bp", 1'b1, 32'hC3, 1'b1, 1'b0);
    cycle("bp", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("bp", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("bp", 1'b0, 32'h0, 1'b1, 1'b0);

    // 4: flush while full
    cycle("fl", 1'b1, 32'h5, 1'b0, 1'b0);
    cycle("fl", 1'b1, 32'h6, 1'b0, 1'b0);
    cycle("fl", 1'b1, 32'h7, 1'b1, 1'b1);
    cycle("fl", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("fl", 1'b0, 32'h0, 1'b1, 1'b0);
    // flush with a push accepted in the same cycle at count=1
    cycle("fl1", 1'b1, 32'h8, 1'b0, 1'b0);
    cycle("fl1", 1'b1, 32'h9, 1'b1, 1'b1);
    cycle("fl1", 1'b0, 32'h0, 1'b1, 1'b0);

    // 5: sustained push&pop at count=1
    cycle("pp", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle("pp", 1'b1, $urandom, 1'b1, 1'b0);
    cycle("pp", 1'b0, 32'h0, 1'b0, 1'b0);

    // 6: async reset mid-cycle while full
    cycle("ar", 1'b1, 32'h12, 1'b0, 1'b0);
    cycle("ar", 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.out_valid", W'(out_valid), W'(0));
    chk("ar.in_ready", W'(in_ready), W'(0));
    chk("ar.count", W'(count), W'(0));
    chk("ar.out_data", out_data, RSTV);
    in_valid = 1'b0;
    do_reset_release();
    cycle("ar_rec0", 1'b1, 32'h34, 1'b1, 1'b0);
    cycle("ar_rec1", 1'b1, 32'h56, 1'b1, 1'b0);
    cycle("ar_rec2", 1'b0, 32'h0, 1'b1, 1'b0);

    // random run; upstream holds an unaccepted word stable
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!(v && !m_ready)) begin
        v = 1'($urandom_range(1));
        d = $urandom;
      end
      r = 1'($urandom_range(1));
      f = ($urandom_range(99) == 0);
      cycle("rnd", v, d, r, f);
      if (f) v = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
